// File: rtl/ascii2at_pkg.sv
// Shared definitions for the keycode-to-PS/2 set-2 injector: special keycodes,
// scan-code constants and the sequencer state type.
// Optional feature macro: ASCII2AT_EXTENDED_EN (E0-prefixed navigation keys).
package ascii2at_pkg;

    // Special (non-printable) keycodes
    localparam logic [7:0] KC_SHIFT = 8'h01;
    localparam logic [7:0] KC_ALT   = 8'h02;
    localparam logic [7:0] KC_CTRL  = 8'h03;
    localparam logic [7:0] KC_UP    = 8'h04;
    localparam logic [7:0] KC_DOWN  = 8'h05;
    localparam logic [7:0] KC_LEFT  = 8'h06;
    localparam logic [7:0] KC_RIGHT = 8'h07;
    localparam logic [7:0] KC_BS    = 8'h08;
    localparam logic [7:0] KC_TAB   = 8'h09;
    localparam logic [7:0] KC_ENTER = 8'h0A;
    localparam logic [7:0] KC_HOME  = 8'h0B;
    localparam logic [7:0] KC_END   = 8'h0C;
    localparam logic [7:0] KC_PGUP  = 8'h0D;
    localparam logic [7:0] KC_PGDN  = 8'h0E;
    localparam logic [7:0] KC_DEL   = 8'h0F;
    localparam logic [7:0] KC_F1    = 8'h10;
    localparam logic [7:0] KC_F2    = 8'h11;
    localparam logic [7:0] KC_F3    = 8'h12;
    localparam logic [7:0] KC_F4    = 8'h13;
    localparam logic [7:0] KC_F5    = 8'h14;
    localparam logic [7:0] KC_F6    = 8'h15;
    localparam logic [7:0] KC_F7    = 8'h16;
    localparam logic [7:0] KC_F8    = 8'h17;
    localparam logic [7:0] KC_F9    = 8'h18;
    localparam logic [7:0] KC_F10   = 8'h19;
    localparam logic [7:0] KC_F11   = 8'h1A;
    localparam logic [7:0] KC_ESC   = 8'h1B;
    localparam logic [7:0] KC_INS   = 8'h1C;
    localparam logic [7:0] KC_NUM   = 8'h1D;
    localparam logic [7:0] KC_F12   = 8'h1E;

    // Scan-code bytes with fixed meaning
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;

    typedef enum logic [3:0] {
        IDLE, SH_MAKE, MAKE_E0, MAKE, BRK_E0, BRK_F0, BRK, SH_F0, SH_BRK, GAPW_ST
    } state_e;

endpackage

// File: rtl/ascii2at_lut.sv
// Keycode -> set-2 scan code lookup; the inverse of the scan-code-to-ASCII table.
// Uppercase letters reuse the lowercase entry with need_shift set.
// Optional feature macro: ASCII2AT_EXTENDED_EN adds the ext output.
module ascii2at_lut
    import ascii2at_pkg::*;
(
    input  logic [7:0] ascii_in,
    output logic       known,
    output logic       need_shift,
`ifdef ASCII2AT_EXTENDED_EN
    output logic       ext,
`endif
    output logic [7:0] code
);

    logic [7:0] lc;

    // Fold case, then decode the keycode into scan code and shift requirement
    always_comb begin
        lc         = ascii_in;
        need_shift = 1'b0;
        known      = 1'b1;
        code       = 8'h00;
        if (ascii_in >= 8'h41 && ascii_in <= 8'h5A) begin
            lc         = ascii_in | 8'h20;
            need_shift = 1'b1;
        end
        case (lc)
            // letters a..z
            8'h61: code = 8'h1C;  8'h62: code = 8'h32;  8'h63: code = 8'h21;  8'h64: code = 8'h23;
            8'h65: code = 8'h24;  8'h66: code = 8'h2B;  8'h67: code = 8'h34;  8'h68: code = 8'h33;
            8'h69: code = 8'h43;  8'h6A: code = 8'h3B;  8'h6B: code = 8'h42;  8'h6C: code = 8'h4B;
            8'h6D: code = 8'h3A;  8'h6E: code = 8'h31;  8'h6F: code = 8'h44;  8'h70: code = 8'h4D;
            8'h71: code = 8'h15;  8'h72: code = 8'h2D;  8'h73: code = 8'h1B;  8'h74: code = 8'h2C;
            8'h75: code = 8'h3C;  8'h76: code = 8'h2A;  8'h77: code = 8'h1D;  8'h78: code = 8'h22;
            8'h79: code = 8'h35;  8'h7A: code = 8'h1A;
            // digits 0..9
            8'h30: code = 8'h45;  8'h31: code = 8'h16;  8'h32: code = 8'h1E;  8'h33: code = 8'h26;
            8'h34: code = 8'h25;  8'h35: code = 8'h2E;  8'h36: code = 8'h36;  8'h37: code = 8'h3D;
            8'h38: code = 8'h3E;  8'h39: code = 8'h46;
            // shifted digit row ) ! @ # $ % ^ & * (
            8'h29: {need_shift, code} = {1'b1, 8'h45};  8'h21: {need_shift, code} = {1'b1, 8'h16};
            8'h40: {need_shift, code} = {1'b1, 8'h1E};  8'h23: {need_shift, code} = {1'b1, 8'h26};
            8'h24: {need_shift, code} = {1'b1, 8'h25};  8'h25: {need_shift, code} = {1'b1, 8'h2E};
            8'h5E: {need_shift, code} = {1'b1, 8'h36};  8'h26: {need_shift, code} = {1'b1, 8'h3D};
            8'h2A: {need_shift, code} = {1'b1, 8'h3E};  8'h28: {need_shift, code} = {1'b1, 8'h46};
            // space and unshifted punctuation (backquote, minus, equals, brackets, backslash,
            // semicolon, quote, comma, period, slash)
            8'h20: code = 8'h29;  8'h60: code = 8'h0E;  8'h2D: code = 8'h4E;  8'h3D: code = 8'h55;
            8'h5B: code = 8'h54;  8'h5D: code = 8'h5B;  8'h5C: code = 8'h5D;  8'h3B: code = 8'h4C;
            8'h27: code = 8'h52;  8'h2C: code = 8'h41;  8'h2E: code = 8'h49;  8'h2F: code = 8'h4A;
            // shifted punctuation ~ _ + { } | : " < > ?
            8'h7E: {need_shift, code} = {1'b1, 8'h0E};  8'h5F: {need_shift, code} = {1'b1, 8'h4E};
            8'h2B: {need_shift, code} = {1'b1, 8'h55};  8'h7B: {need_shift, code} = {1'b1, 8'h54};
            8'h7D: {need_shift, code} = {1'b1, 8'h5B};  8'h7C: {need_shift, code} = {1'b1, 8'h5D};
            8'h3A: {need_shift, code} = {1'b1, 8'h4C};  8'h22: {need_shift, code} = {1'b1, 8'h52};
            8'h3C: {need_shift, code} = {1'b1, 8'h41};  8'h3E: {need_shift, code} = {1'b1, 8'h49};
            8'h3F: {need_shift, code} = {1'b1, 8'h4A};
            // special keys; SHIFT uses the left-shift code
            KC_SHIFT: code = 8'h12;  KC_ALT:  code = 8'h11;  KC_CTRL:  code = 8'h14;
            KC_UP:    code = 8'h75;  KC_DOWN: code = 8'h72;  KC_LEFT:  code = 8'h6B;
            KC_RIGHT: code = 8'h74;  KC_BS:   code = 8'h66;  KC_TAB:   code = 8'h0D;
            KC_ENTER: code = 8'h5A;  KC_HOME: code = 8'h6C;  KC_END:   code = 8'h69;
            KC_PGUP:  code = 8'h7D;  KC_PGDN: code = 8'h7A;  KC_DEL:   code = 8'h71;
            KC_F1:    code = 8'h05;  KC_F2:   code = 8'h06;  KC_F3:    code = 8'h04;
            KC_F4:    code = 8'h0C;  KC_F5:   code = 8'h03;  KC_F6:    code = 8'h0B;
            KC_F7:    code = 8'h83;  KC_F8:   code = 8'h0A;  KC_F9:    code = 8'h01;
            KC_F10:   code = 8'h09;  KC_F11:  code = 8'h78;  KC_ESC:   code = 8'h76;
            KC_INS:   code = 8'h70;  KC_NUM:  code = 8'h77;  KC_F12:   code = 8'h07;
            default:  known = 1'b0;
        endcase
    end

`ifdef ASCII2AT_EXTENDED_EN
    // Navigation keys that carry the E0 prefix; none of them ever needs shift
    assign ext = ascii_in inside {KC_UP, KC_DOWN, KC_LEFT, KC_RIGHT, KC_HOME, KC_END,
                                  KC_PGUP, KC_PGDN, KC_DEL, KC_INS};
`endif

endmodule

// File: rtl/ascii2at_seq.sv
// Emits the make/break scan-code sequence for one accepted keycode over a
// valid/ready byte stream, with an optional idle gap between bytes.
// Optional feature macro: ASCII2AT_EXTENDED_EN (E0 prefix for navigation keys).
module ascii2at_seq
    import ascii2at_pkg::*;
#(
    parameter int unsigned GAP  = 0,
    parameter int unsigned GAPW = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] ascii_in,
    input  logic       ascii_valid,
    output logic       ascii_ready,
    output logic [7:0] code_out,
    output logic       code_valid,
    input  logic       code_ready,
    output logic       busy,
    output logic       unknown
);

    state_e            state_q, state_d, ret_q, ret_d, after;
    logic [GAPW-1:0]   gap_q, gap_d;
    logic [7:0]        k_q;
    logic              shift_q;
    logic              unknown_q;
    logic              lut_known, lut_shift;
    logic [7:0]        lut_code;
    logic              accept, handshake;
`ifdef ASCII2AT_EXTENDED_EN
    logic              ext_q, lut_ext;
`endif

    ascii2at_lut u_lut (
        .ascii_in   (ascii_in),
        .known      (lut_known),
        .need_shift (lut_shift),
`ifdef ASCII2AT_EXTENDED_EN
        .ext        (lut_ext),
`endif
        .code       (lut_code)
    );

    assign ascii_ready = (state_q == IDLE) && !reset;
    assign accept      = ascii_valid && ascii_ready;
    assign handshake   = code_valid && code_ready;
    assign busy        = (state_q != IDLE);
    assign unknown     = unknown_q;

    // Byte presented in each state and the byte state that follows it
    always_comb begin
        code_valid = 1'b1;
        code_out   = 8'h00;
        after      = IDLE;
        case (state_q)
            SH_MAKE: begin code_out = SC_LSHIFT; after = MAKE;   end
`ifdef ASCII2AT_EXTENDED_EN
            MAKE_E0: begin code_out = SC_EXT;    after = MAKE;   end
            MAKE:    begin code_out = k_q;       after = ext_q ? BRK_E0 : BRK_F0; end
            BRK_E0:  begin code_out = SC_EXT;    after = BRK_F0; end
`else
            MAKE:    begin code_out = k_q;       after = BRK_F0; end
`endif
            BRK_F0:  begin code_out = SC_BREAK;  after = BRK;    end
            BRK:     begin code_out = k_q;       after = shift_q ? SH_F0 : IDLE; end
            SH_F0:   begin code_out = SC_BREAK;  after = SH_BRK; end
            SH_BRK:  begin code_out = SC_LSHIFT; after = IDLE;   end
            default: code_valid = 1'b0;
        endcase
    end

    // Next state: start on a mapped keycode, advance on handshake, count the gap
    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        gap_d   = gap_q;
        if (state_q == IDLE) begin
            if (accept && lut_known) begin
`ifdef ASCII2AT_EXTENDED_EN
                state_d = lut_shift ? SH_MAKE : (lut_ext ? MAKE_E0 : MAKE);
`else
                state_d = lut_shift ? SH_MAKE : MAKE;
`endif
            end
        end else if (state_q == GAPW_ST) begin
            if (gap_q == '0) begin
                state_d = ret_q;
            end else begin
                gap_d = gap_q - 1'b1;
            end
        end else if (handshake) begin
            if (after == IDLE || GAP == 0) begin
                state_d = after;
            end else begin
                state_d = GAPW_ST;
                ret_d   = after;
                gap_d   = GAPW'(GAP - 1);
            end
        end
    end

    // State, latched lookup result and unknown pulse; reset aborts any sequence
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            ret_q     <= IDLE;
            gap_q     <= '0;
            k_q       <= 8'h00;
            shift_q   <= 1'b0;
            unknown_q <= 1'b0;
`ifdef ASCII2AT_EXTENDED_EN
            ext_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            gap_q     <= gap_d;
            unknown_q <= accept && !lut_known;
            if (accept) begin
                k_q     <= lut_code;
                shift_q <= lut_shift;
`ifdef ASCII2AT_EXTENDED_EN
                ext_q   <= lut_ext;
`endif
            end
        end
    end

endmodule

// File: tb/tb_ascii2at_seq.sv
// Self-checking bench for ascii2at_seq: two instances (GAP=0 and GAP=3) driven
// with directed and random keycodes against a table-driven reference model.
module tb_ascii2at_seq;

    localparam int unsigned GAP1 = 3;

    logic       clock = 1'b0;
    logic       reset    [2];
    logic [7:0] a_in     [2];
    logic       a_valid  [2];
    logic       a_ready  [2];
    logic [7:0] c_out    [2];
    logic       c_valid  [2];
    logic       c_ready  [2];
    logic       busy     [2];
    logic       unk      [2];

    always #5 clock = ~clock;

    ascii2at_seq #(.GAP(0), .GAPW(8)) dut0 (
        .clock(clock), .reset(reset[0]), .ascii_in(a_in[0]), .ascii_valid(a_valid[0]),
        .ascii_ready(a_ready[0]), .code_out(c_out[0]), .code_valid(c_valid[0]),
        .code_ready(c_ready[0]), .busy(busy[0]), .unknown(unk[0])
    );

    ascii2at_seq #(.GAP(GAP1), .GAPW(4)) dut1 (
        .clock(clock), .reset(reset[1]), .ascii_in(a_in[1]), .ascii_valid(a_valid[1]),
        .ascii_ready(a_ready[1]), .code_out(c_out[1]), .code_valid(c_valid[1]),
        .code_ready(c_ready[1]), .busy(busy[1]), .unknown(unk[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Reference model: keycode tables built from character strings
    logic [7:0] m_code  [256];
    bit         m_known [256];
    bit         m_shift [256];
    bit         m_ext   [256];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    function automatic void put(input logic [7:0] ch, input logic [7:0] sc, input bit sh);
        m_known[ch] = 1'b1;
        m_code[ch]  = sc;
        m_shift[ch] = sh;
    endfunction

    function automatic void model_init();
        string letters = "abcdefghijklmnopqrstuvwxyz";
        string digits  = "0123456789";
        string sdigits = ")!@#$%^&*(";
        logic [7:0] plain   [11] = '{8'h60, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27,
                                     8'h2C, 8'h2E, 8'h2F};
        logic [7:0] shifted [11] = '{8'h7E, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22,
                                     8'h3C, 8'h3E, 8'h3F};
        logic [7:0] let_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                    8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                    8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                    8'h35, 8'h1A};
        logic [7:0] dig_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                    8'h3E, 8'h46};
        logic [7:0] sym_sc [11] = '{8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52,
                                    8'h41, 8'h49, 8'h4A};
        logic [7:0] spc_sc [30] = '{8'h12, 8'h11, 8'h14, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h66,
                                    8'h0D, 8'h5A, 8'h6C, 8'h69, 8'h7D, 8'h7A, 8'h71, 8'h05,
                                    8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B, 8'h83, 8'h0A, 8'h01,
                                    8'h09, 8'h78, 8'h76, 8'h70, 8'h77, 8'h07};
        for (int i = 0; i < 256; i++) begin
            m_known[i] = 1'b0; m_code[i] = 8'h00; m_shift[i] = 1'b0; m_ext[i] = 1'b0;
        end
        for (int i = 0; i < 26; i++) begin
            put(8'(letters[i]), let_sc[i], 1'b0);
            put(8'(letters[i]) - 8'h20, let_sc[i], 1'b1);
        end
        for (int i = 0; i < 10; i++) begin
            put(8'(digits[i]), dig_sc[i], 1'b0);
            put(8'(sdigits[i]), dig_sc[i], 1'b1);
        end
        for (int i = 0; i < 11; i++) begin
            put(plain[i], sym_sc[i], 1'b0);
            put(shifted[i], sym_sc[i], 1'b1);
        end
        put(8'h20, 8'h29, 1'b0);
        for (int i = 0; i < 30; i++) put(8'(i + 1), spc_sc[i], 1'b0);
`ifdef ASCII2AT_EXTENDED_EN
        for (int i = 4; i <= 7; i++) m_ext[i] = 1'b1;
        for (int i = 8'h0B; i <= 8'h0F; i++) m_ext[i] = 1'b1;
        m_ext[8'h1C] = 1'b1;
`endif
    endfunction

    // Expected byte stream for one tap of a keycode
    function automatic void model_seq(input logic [7:0] ch);
        logic [7:0] k;
        exp_q.delete();
        if (!m_known[ch]) return;
        k = m_code[ch];
        if (m_ext[ch]) begin
            exp_q.push_back(8'hE0); exp_q.push_back(k);
            exp_q.push_back(8'hE0); exp_q.push_back(8'hF0); exp_q.push_back(k);
        end else if (m_shift[ch]) begin
            exp_q.push_back(8'h12); exp_q.push_back(k); exp_q.push_back(8'hF0);
            exp_q.push_back(k); exp_q.push_back(8'hF0); exp_q.push_back(8'h12);
        end else begin
            exp_q.push_back(k); exp_q.push_back(8'hF0); exp_q.push_back(k);
        end
    endfunction

    // Scan-code-to-ASCII loopback with shift tracking; returns the first make keycode
    function automatic logic [7:0] decode_make();
        bit sh = 1'b0;
        bit brk = 1'b0;
        logic [7:0] r = 8'h00;
        foreach (got_q[i]) begin
            if (got_q[i] == 8'hF0) brk = 1'b1;
            else if (got_q[i] != 8'hE0) begin
                if (got_q[i] == 8'h12) sh = !brk;
                else if (!brk && r == 8'h00) begin
                    for (int c = 8'h20; c < 8'h7F; c++)
                        if (m_known[c] && m_code[c] == got_q[i] && m_shift[c] == sh) r = 8'(c);
                end
                brk = 1'b0;
            end
        end
        return r;
    endfunction

    task automatic pulse_reset(input int d);
        reset[d] = 1'b1;
        @(negedge clock);
        reset[d] = 1'b0;
    endtask

    // Send one keycode on instance d and check every output byte and its timing
    task automatic send(input int d, input logic [7:0] ch, input int stall_pct,
                        input int stall_at, input int stall_len);
        int idx = 0, gapc = 0, held = 0, budget = 0;
        int gap_want = (d == 1) ? int'(GAP1) : 0;
        bit pend = 1'b0;
        bit rdy;
        logic [7:0] pend_val = 8'h00;
        model_seq(ch);
        got_q.delete();
        @(negedge clock);
        check_val("ready_idle", a_ready[d], 1);
        a_in[d] = ch; a_valid[d] = 1'b1; c_ready[d] = 1'b1;
        @(negedge clock);
        a_valid[d] = 1'b0;
        if (exp_q.size() == 0) begin
            check_val("unknown_set", unk[d], 1);
            check_val("unknown_novalid", c_valid[d], 0);
            check_val("unknown_ready", a_ready[d], 1);
            check_val("unknown_busy", busy[d], 0);
            @(negedge clock);
            check_val("unknown_clear", unk[d], 0);
            check_val("unknown_novalid2", c_valid[d], 0);
            return;
        end
        while (idx < exp_q.size() && budget < 400) begin
            check_val("busy", busy[d], 1);
            check_val("no_unknown", unk[d], 0);
            if (pend) begin
                check_val("hold_valid", c_valid[d], 1);
                check_val("hold_data", c_out[d], pend_val);
                pend = 1'b0;
            end
            if (c_valid[d]) begin
                if (idx == stall_at && held < stall_len) rdy = 1'b0;
                else rdy = ($urandom_range(99) >= stall_pct);
                c_ready[d] = rdy;
                if (rdy) begin
                    check_val($sformatf("gap%0d", idx), gapc, (idx == 0) ? 0 : gap_want);
                    check_val($sformatf("byte%0d", idx), c_out[d], exp_q[idx]);
                    got_q.push_back(c_out[d]);
                    idx++; gapc = 0; held = 0;
                end else begin
                    pend = 1'b1; pend_val = c_out[d]; held++;
                end
            end else begin
                gapc++;
                c_ready[d] = 1'($urandom_range(1));
            end
            @(negedge clock);
            budget++;
        end
        c_ready[d] = 1'b1;
        if (idx < exp_q.size()) begin
            check_val("timeout", idx, exp_q.size());
            pulse_reset(d);
        end else begin
            check_val("idle_busy", busy[d], 0);
            check_val("idle_ready", a_ready[d], 1);
            check_val("idle_valid", c_valid[d], 0);
        end
    endtask

    initial begin
        logic [7:0] ch;
        int d;
        model_init();
        for (int i = 0; i < 2; i++) begin
            reset[i] = 1'b1; a_in[i] = 8'h00; a_valid[i] = 1'b0; c_ready[i] = 1'b1;
        end
        repeat (2) @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            check_val("rst_ready", a_ready[i], 0);
            check_val("rst_valid", c_valid[i], 0);
            check_val("rst_code", c_out[i], 8'h00);
            check_val("rst_busy", busy[i], 0);
            check_val("rst_unknown", unk[i], 0);
        end
        reset[0] = 1'b0; reset[1] = 1'b0;
        @(negedge clock);
        check_val("post_rst_ready0", a_ready[0], 1);
        check_val("post_rst_ready1", a_ready[1], 1);

        // Directed cases
        send(0, 8'h61, 0, -1, 0);
        send(0, 8'h41, 0, -1, 0);
        check_val("loopback_A", decode_make(), 8'h41);
        send(0, 8'h31, 0, 1, 5);
        send(1, 8'h20, 0, -1, 0);
        send(0, 8'h7F, 0, -1, 0);
        send(0, 8'h80, 0, -1, 0);
        send(0, 8'h04, 0, -1, 0);
        send(1, 8'h7E, 30, -1, 0);

        // Reset while the second byte of up-arrow is on the bus
        model_seq(8'h04);
        @(negedge clock);
        a_in[0] = 8'h04; a_valid[0] = 1'b1; c_ready[0] = 1'b1;
        @(negedge clock);
        a_valid[0] = 1'b0;
        check_val("rst_seq_b0", c_out[0], exp_q[0]);
        @(negedge clock);
        check_val("rst_seq_b1_valid", c_valid[0], 1);
        check_val("rst_seq_b1", c_out[0], exp_q[1]);
        reset[0] = 1'b1;
        @(negedge clock);
        check_val("rst_abort_valid", c_valid[0], 0);
        check_val("rst_abort_busy", busy[0], 0);
        check_val("rst_abort_ready", a_ready[0], 0);
        reset[0] = 1'b0;
        @(negedge clock);
        check_val("rst_abort_idle", a_ready[0], 1);
        check_val("rst_abort_quiet", c_valid[0], 0);

        // Random keycodes, instances and downstream stalls
        for (int n = 0; n < 60; n++) begin
            d  = int'($urandom_range(1));
            ch = ($urandom_range(3) == 0) ? 8'($urandom_range(255)) : 8'($urandom_range(8'h7E));
            send(d, ch, int'($urandom_range(40)), -1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
